// File: rtl/button_event_decoder.sv
// Turns a debounced button level into single-cycle short/long/double/repeat
// events plus a held level, with all timing measured in tick periods.
module button_event_decoder #(
    parameter int LONG_TICKS   = 500,
    parameter int DOUBLE_TICKS = 250,
    parameter int REPEAT_TICKS = 100,
    parameter int CNT_W        = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic btn_level,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic repeat_pulse,   // "repeat" is a reserved word in SystemVerilog
    output logic held
);

    typedef enum logic [2:0] {
        IDLE, PRESSED, LONG_HELD, WAIT_SECOND, SECOND_PRESSED
    } state_t;

    localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] DOUBLE_TC = CNT_W'(DOUBLE_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_TICKS - 1);

    state_t           state, next_state;
    logic             prev;
    logic [CNT_W-1:0] timer;
    logic             rise, fall;
    logic             timer_clr, counting;
    logic             short_n, long_n, double_n, repeat_n;

    assign rise = btn_level & ~prev;
    assign fall = ~btn_level & prev;

    // Only the timed states advance the timer, so it cannot wrap while idle.
    assign counting = (state == PRESSED) || (state == LONG_HELD) || (state == WAIT_SECOND);

    always_comb begin
        next_state = state;
        timer_clr  = 1'b0;
        short_n    = 1'b0;
        long_n     = 1'b0;
        double_n   = 1'b0;
        repeat_n   = 1'b0;
        unique case (state)
            IDLE: if (rise) next_state = PRESSED;
            PRESSED: begin
                if (fall) begin
                    next_state = WAIT_SECOND;
                end else if (tick && timer == LONG_TC) begin
                    long_n     = 1'b1;
                    next_state = LONG_HELD;
                end
            end
            LONG_HELD: begin
                if (fall) begin
                    next_state = IDLE;
                end else if (tick && timer == REPEAT_TC) begin
                    repeat_n  = 1'b1;
                    timer_clr = 1'b1;
                end
            end
            WAIT_SECOND: begin
                if (rise) begin
                    double_n   = 1'b1;
                    next_state = SECOND_PRESSED;
                end else if (tick && timer == DOUBLE_TC) begin
                    short_n    = 1'b1;
                    next_state = IDLE;
                end
            end
            SECOND_PRESSED: if (fall) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            prev         <= 1'b1;
            timer        <= '0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_click <= 1'b0;
            repeat_pulse <= 1'b0;
            held         <= 1'b0;
        end else begin
            state        <= next_state;
            prev         <= btn_level;
            if (next_state != state || timer_clr)
                timer <= '0;
            else if (tick && counting)
                timer <= timer + 1'b1;
            short_press  <= short_n;
            long_press   <= long_n;
            double_click <= double_n;
            repeat_pulse <= repeat_n;
            held         <= (next_state == LONG_HELD);
        end
    end

endmodule
